// File: rtl/register_file.sv
// Architectural register file with two registered read ports, one write
// port (port D from writeback) and a per-register busy scoreboard.
//
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   portD_*             write strobe/key/value from writeback; clears busy
//   reserve_*           mark a destination busy (key 0 needs special)
//   portA_*, portB_*    read request (enable/key/special) and registered
//                       value/busy results, one cycle after the request
//
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle
// port-D writes and reservations into the read results.

module register_file #(
  parameter int NUM_REGS   = 32,
  parameter int DATA_WIDTH = 32,
  parameter int KEY_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  portD_enable,
  input  logic [KEY_WIDTH-1:0]  portD_key,
  input  logic [DATA_WIDTH-1:0] portD_value,
  input  logic                  reserve_enable,
  input  logic [KEY_WIDTH-1:0]  reserve_key,
  input  logic                  reserve_special,
  input  logic                  portA_enable,
  input  logic [KEY_WIDTH-1:0]  portA_key,
  input  logic                  portA_special,
  output logic [DATA_WIDTH-1:0] portA_value,
  output logic                  portA_busy,
  input  logic                  portB_enable,
  input  logic [KEY_WIDTH-1:0]  portB_key,
  input  logic                  portB_special,
  output logic [DATA_WIDTH-1:0] portB_value,
  output logic                  portB_busy
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_next;
  logic                  reserve_ok;

  logic [DATA_WIDTH-1:0] a_src_value;
  logic [DATA_WIDTH-1:0] b_src_value;
  logic                  a_src_busy;
  logic                  b_src_busy;
  logic [DATA_WIDTH-1:0] a_value;
  logic [DATA_WIDTH-1:0] b_value;
  logic                  a_busy;
  logic                  b_busy;

  // Key 0 may only be reserved through the special path.
  assign reserve_ok = reserve_enable &&
                      ((reserve_key != '0) || reserve_special);

  // Reserve is applied after the write so a newer producer wins.
  always_comb begin
    busy_next = busy;
    if (portD_enable) begin
      busy_next[portD_key] = 1'b0;
    end
    if (reserve_ok) begin
      busy_next[reserve_key] = 1'b1;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign a_src_value = (portD_enable && (portD_key == portA_key)) ?
                       portD_value : regs[portA_key];
  assign b_src_value = (portD_enable && (portD_key == portB_key)) ?
                       portD_value : regs[portB_key];
  assign a_src_busy  = busy_next[portA_key];
  assign b_src_busy  = busy_next[portB_key];
`else
  assign a_src_value = regs[portA_key];
  assign b_src_value = regs[portB_key];
  assign a_src_busy  = busy[portA_key];
  assign b_src_busy  = busy[portB_key];
`endif

  // Non-special reads of key 0 behave as a hardwired zero register.
  always_comb begin
    a_value = a_src_value;
    a_busy  = a_src_busy;
    if ((portA_key == '0) && !portA_special) begin
      a_value = '0;
      a_busy  = 1'b0;
    end
  end

  always_comb begin
    b_value = b_src_value;
    b_busy  = b_src_busy;
    if ((portB_key == '0) && !portB_special) begin
      b_value = '0;
      b_busy  = 1'b0;
    end
  end

  // Storage: key 0 is written unconditionally, writeback filters it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (portD_enable) begin
      regs[portD_key] <= portD_value;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      portA_value <= '0;
      portA_busy  <= 1'b0;
    end else if (portA_enable) begin
      portA_value <= a_value;
      portA_busy  <= a_busy;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      portB_value <= '0;
      portB_busy  <= 1'b0;
    end else if (portB_enable) begin
      portB_value <= b_value;
      portB_busy  <= b_busy;
    end
  end

endmodule
